branch_predict_unit: RTL and testbench
======================================

Name: branch_predict_unit

Overview:
- Parametrised successor to the combinational branch resolver.
- Resolves one branch/jump per cycle using the same instruction IDs (15–23) and the same taken/offset output rule.
- Adds three sequential functions: a registered result stage, a PC-indexed table of 2-bit saturating counters that the fetch stage reads for prediction, and a return-address stack (RAS) for jal/jr.
- Sits between decode/execute (resolve port) and fetch (lookup port). Also exposes saturating branch/mispredict statistics.

Parameters:
- DATA_W, 32, width of rs/rt/rd/pc/out.
- IDX_W, 6, counter-table index bits (table depth = 2**IDX_W).
- RAS_DEPTH, 8, return-address stack entries (power of two, ≥2).
- CNT_W, 16, width of statistics counters.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high.
- valid  in  1  resolve request this cycle.
- pc  in  DATA_W  PC of the instruction being resolved.
- ID  in  32  decoded instruction ID.
- rs  in  DATA_W  operand 1, or jump target for j/jr/jal.
- rt  in  DATA_W  operand 2.
- rd  in  DATA_W  branch offset.
- pred_in  in  1  prediction fetch made for this instruction.
- lu_pc  in  DATA_W  fetch lookup PC.
- lu_taken  out  1  prediction for lu_pc (combinational).
- out_valid  out  1  registered result valid.
- out  out  DATA_W  offset/target if taken, else 0.
- taken  out  1  resolved direction.
- mispredict  out  1  taken != pred_in (registered).
- ras_top  out  DATA_W  current RAS top (0 when empty).
- ras_empty  out  1  RAS holds no entries.
- br_count  out  CNT_W  conditional branches resolved.
- mp_count  out  CNT_W  mispredicts.

Behaviour:
- Reset:
  - Outputs: out_valid=0, out=0, taken=0, mispredict=0, ras_empty=1, ras_top=0, br_count=0, mp_count=0.
  - All table counters = 2'b01 (weakly not-taken). RAS pointer = 0, RAS count = 0.
  - Reset arriving mid-operation discards any in-flight result: out_valid=0 on the following cycle.
- Resolution (all comparisons signed):
  - 15 beq: taken if rs==rt.
  - 16 bne: taken if rs!=rt.
  - 17 bgt: taken if rs>rt.
  - 18 bgte: taken if rs>=rt.
  - 19 ble: taken if rs<rt.
  - 20 bleq: taken if rs<=rt.
  - Conditional branches (15–20): out = taken ? rd : 0.
  - 21 j, 22 jr, 23 jal: always taken; out = rs.
  - Any other ID: taken=0, out=0, no state change.
- Latency: exactly 1 cycle. Inputs sampled at edge N give out_valid/out/taken/mispredict during cycle N+1. If valid=0, out_valid=0 and the other outputs hold their previous values.
- Mispredict:
  - IDs 15–20: taken XOR pred_in.
  - IDs 21–23: !pred_in.
  - Other IDs: 0.
- Counter table:
  - Index = pc[IDX_W-1:0].
  - Updated only for IDs 15–20 with valid=1: increment if taken, decrement if not, saturating at 3 and 0.
  - lu_taken = counter[lu_pc[IDX_W-1:0]][1].
  - Same-cycle lookup and update at the same index: lu_taken returns the pre-update value (read-before-write).
- RAS:
  - jal pushes pc+1, wrapping modulo 2**DATA_W.
  - jr pops. The popped value is informational only; out still equals rs.
  - Push when full overwrites the oldest entry (circular); count saturates at RAS_DEPTH.
  - Pop when empty is a no-op: ras_empty stays 1, ras_top=0.
  - ras_top and ras_empty are registered and reflect the push/pop in the cycle after it.
- Statistics:
  - br_count increments on each valid ID 15–20.
  - mp_count increments on each mispredict, for any ID.
  - Both saturate at 2**CNT_W-1 and never wrap.

Decomposition:
- Shared package (branch_pkg) holds:
  - instruction ID constants: ID_BEQ=15 … ID_JAL=23;
  - counter encodings: SNT=0, WNT=1, WT=2, ST=3;
  - an is_cond_branch(ID) function.
- One sub-module, branch_ras: a parametrised circular stack with push/pop/top/empty ports.
- Comparator logic and the counter table stay in the top module.

Test Plan:
- Reset, then valid beq (pc=4, rs=10, rt=12, rd=1, pred_in=0) -> next cycle: out_valid=1, out=0, taken=0, mispredict=0, br_count=1; counter[4] moves 1→0.
- Four valid bne at pc=8 (rs=10, rt=12, rd=2, pred_in=0):
  - each -> out=2, taken=1, mispredict=1;
  - after the 2nd, lu_pc=8 gives lu_taken=1;
  - counter saturates at 3;
  - mp_count=4.
- bgte rs=10, rt=10, rd=99 -> out=99. ble rs=10, rt=10 -> out=0. bleq rs=-1, rt=0 -> out=99 (signed compare).
- jal pc=40, rs=100 -> out=100, taken=1, ras_top=41. Then jr rs=5 -> out=5, ras_empty=1. Then jr again -> ras_empty stays 1, ras_top=0.
- RAS_DEPTH+1 jal pushes at pc=0,1,…,8 -> ras_top=9. Popping 8 times returns 9…2, then ras_empty=1 (entry for pc=0 overwritten).
- Same-cycle update and lookup at index 3: lu_taken reflects the old counter. Reset asserted while valid=1 -> next cycle out_valid=0, br_count=0.

Source files
------------

// File: rtl/branch_pkg.sv
// Shared definitions for the branch predict unit: instruction IDs,
// 2-bit counter encodings and small decode/update helpers.
package branch_pkg;

   localparam logic [31:0] ID_BEQ  = 32'd15;
   localparam logic [31:0] ID_BNE  = 32'd16;
   localparam logic [31:0] ID_BGT  = 32'd17;
   localparam logic [31:0] ID_BGTE = 32'd18;
   localparam logic [31:0] ID_BLE  = 32'd19;
   localparam logic [31:0] ID_BLEQ = 32'd20;
   localparam logic [31:0] ID_J    = 32'd21;
   localparam logic [31:0] ID_JR   = 32'd22;
   localparam logic [31:0] ID_JAL  = 32'd23;

   typedef enum logic [1:0] {
      SNT = 2'd0,
      WNT = 2'd1,
      WT  = 2'd2,
      ST  = 2'd3
   } ctr_e;

   function automatic logic is_cond_branch(input logic [31:0] id);
      return (id >= ID_BEQ) && (id <= ID_BLEQ);
   endfunction

   function automatic logic is_jump(input logic [31:0] id);
      return (id >= ID_J) && (id <= ID_JAL);
   endfunction

   // Saturating 2-bit counter step toward the resolved direction.
   function automatic logic [1:0] ctr_next(input logic [1:0] c, input logic tk);
      logic [1:0] n;
      if (tk) begin
         n = (c == 2'(ST)) ? 2'(ST) : c + 2'd1;
      end else begin
         n = (c == 2'(SNT)) ? 2'(SNT) : c - 2'd1;
      end
      return n;
   endfunction

endpackage

// File: rtl/branch_predict_unit_if.sv
// Resolve, lookup and status bundle between decode/execute, fetch and the
// branch predict unit.
interface branch_predict_unit_if #(
   parameter int DATA_W = 32,
   parameter int CNT_W  = 16
);
   logic              valid;
   logic [DATA_W-1:0] pc;
   logic [31:0]       ID;
   logic [DATA_W-1:0] rs;
   logic [DATA_W-1:0] rt;
   logic [DATA_W-1:0] rd;
   logic              pred_in;
   logic [DATA_W-1:0] lu_pc;
   logic              lu_taken;
   logic              out_valid;
   logic [DATA_W-1:0] out;
   logic              taken;
   logic              mispredict;
   logic [DATA_W-1:0] ras_top;
   logic              ras_empty;
   logic [CNT_W-1:0]  br_count;
   logic [CNT_W-1:0]  mp_count;

   modport master (
      output valid, pc, ID, rs, rt, rd, pred_in, lu_pc,
      input  lu_taken, out_valid, out, taken, mispredict,
             ras_top, ras_empty, br_count, mp_count
   );

   modport slave (
      input  valid, pc, ID, rs, rt, rd, pred_in, lu_pc,
      output lu_taken, out_valid, out, taken, mispredict,
             ras_top, ras_empty, br_count, mp_count
   );
endinterface

// File: rtl/branch_ras.sv
// Circular return-address stack; a push when full overwrites the oldest
// entry, a pop when empty is ignored. top/empty are registered.
module branch_ras #(
   parameter int DATA_W = 32,
   parameter int DEPTH  = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              push,
   input  logic              pop,
   input  logic [DATA_W-1:0] push_data,
   output logic [DATA_W-1:0] top,
   output logic              empty
);
   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = $clog2(DEPTH + 1);

   logic [DATA_W-1:0] mem_r [DEPTH];
   logic [PTR_W-1:0]  ptr_r;
   logic [CNT_W-1:0]  cnt_r;
   logic [DATA_W-1:0] top_r;
   logic              empty_r;
   logic [DATA_W-1:0] top_next_s;
   logic              empty_next_s;

   // Next top-of-stack value, i.e. what top will show after this cycle's op.
   always_comb begin
      top_next_s   = top_r;
      empty_next_s = empty_r;
      if (push) begin
         top_next_s   = push_data;
         empty_next_s = 1'b0;
      end else if (pop && (cnt_r > CNT_W'(1))) begin
         top_next_s   = mem_r[ptr_r - PTR_W'(2)];
         empty_next_s = 1'b0;
      end else if (pop) begin
         top_next_s   = {DATA_W{1'b0}};
         empty_next_s = 1'b1;
      end else begin
         top_next_s   = top_r;
         empty_next_s = empty_r;
      end
   end

   // Stack storage, write pointer and occupancy.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_r[i] <= {DATA_W{1'b0}};
         end
         ptr_r   <= {PTR_W{1'b0}};
         cnt_r   <= {CNT_W{1'b0}};
         top_r   <= {DATA_W{1'b0}};
         empty_r <= 1'b1;
      end else begin
         top_r   <= top_next_s;
         empty_r <= empty_next_s;
         if (push) begin
            mem_r[ptr_r] <= push_data;
            ptr_r        <= ptr_r + PTR_W'(1);
            if (cnt_r != CNT_W'(DEPTH)) begin
               cnt_r <= cnt_r + CNT_W'(1);
            end
         end else if (pop && (cnt_r != {CNT_W{1'b0}})) begin
            ptr_r <= ptr_r - PTR_W'(1);
            cnt_r <= cnt_r - CNT_W'(1);
         end
      end
   end

   assign top   = top_r;
   assign empty = empty_r;
endmodule

// File: rtl/branch_predict_unit.sv
// Branch/jump resolver with registered result, 2-bit counter prediction
// table, return-address stack and saturating statistics.
module branch_predict_unit
   import branch_pkg::*;
#(
   parameter int DATA_W    = 32,
   parameter int IDX_W     = 6,
   parameter int RAS_DEPTH = 8,
   parameter int CNT_W     = 16
) (
   input  logic           clk,
   input  logic           reset,
   branch_predict_unit_if.slave bus
);
   localparam int               TBL_DEPTH = 2 ** IDX_W;
   localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};

   logic [1:0]               table_r [TBL_DEPTH];
   logic                     out_valid_r, taken_r, mp_r;
   logic [DATA_W-1:0]        out_r;
   logic [CNT_W-1:0]         br_count_r, mp_count_r;
   logic signed [DATA_W-1:0] rs_s, rt_s;
   logic                     cmp_s, cond_s, taken_s, mp_s, push_s, pop_s;
   logic [DATA_W-1:0]        out_s;
   logic [IDX_W-1:0]         idx_s;

   assign idx_s = bus.pc[IDX_W-1:0];

   // Signed compare and taken/offset/mispredict rule for the current request.
   always_comb begin
      rs_s    = $signed(bus.rs);
      rt_s    = $signed(bus.rt);
      cmp_s   = 1'b0;
      taken_s = 1'b0;
      out_s   = {DATA_W{1'b0}};
      mp_s    = 1'b0;
      cond_s  = is_cond_branch(bus.ID);
      case (bus.ID)
         ID_BEQ:  cmp_s = (rs_s == rt_s);
         ID_BNE:  cmp_s = (rs_s != rt_s);
         ID_BGT:  cmp_s = (rs_s >  rt_s);
         ID_BGTE: cmp_s = (rs_s >= rt_s);
         ID_BLE:  cmp_s = (rs_s <  rt_s);
         ID_BLEQ: cmp_s = (rs_s <= rt_s);
         default: cmp_s = 1'b0;
      endcase
      if (cond_s) begin
         taken_s = cmp_s;
         out_s   = cmp_s ? bus.rd : {DATA_W{1'b0}};
         mp_s    = cmp_s ^ bus.pred_in;
      end else if (is_jump(bus.ID)) begin
         taken_s = 1'b1;
         out_s   = bus.rs;
         mp_s    = ~bus.pred_in;
      end else begin
         taken_s = 1'b0;
         out_s   = {DATA_W{1'b0}};
         mp_s    = 1'b0;
      end
      push_s = bus.valid && (bus.ID == ID_JAL);
      pop_s  = bus.valid && (bus.ID == ID_JR);
   end

   // Result stage: direction fields hold their value while no request is valid.
   always_ff @(posedge clk) begin
      if (reset) begin
         out_valid_r <= 1'b0;
         out_r       <= {DATA_W{1'b0}};
         taken_r     <= 1'b0;
         mp_r        <= 1'b0;
      end else if (bus.valid) begin
         out_valid_r <= 1'b1;
         out_r       <= out_s;
         taken_r     <= taken_s;
         mp_r        <= mp_s;
      end else begin
         out_valid_r <= 1'b0;
      end
   end

   // Saturating branch and mispredict statistics.
   always_ff @(posedge clk) begin
      if (reset) begin
         br_count_r <= {CNT_W{1'b0}};
         mp_count_r <= {CNT_W{1'b0}};
      end else begin
         if (bus.valid && cond_s && (br_count_r != CNT_MAX)) begin
            br_count_r <= br_count_r + {{(CNT_W-1){1'b0}}, 1'b1};
         end
         if (bus.valid && mp_s && (mp_count_r != CNT_MAX)) begin
            mp_count_r <= mp_count_r + {{(CNT_W-1){1'b0}}, 1'b1};
         end
      end
   end

   // Prediction table training; lookups read the pre-update contents.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < TBL_DEPTH; i++) begin
            table_r[i] <= WNT;
         end
      end else if (bus.valid && cond_s) begin
         table_r[idx_s] <= ctr_next(table_r[idx_s], cmp_s);
      end
   end

   branch_ras #(
      .DATA_W (DATA_W),
      .DEPTH  (RAS_DEPTH)
   ) u_ras (
      .clk       (clk),
      .reset     (reset),
      .push      (push_s),
      .pop       (pop_s),
      .push_data (bus.pc + {{(DATA_W-1){1'b0}}, 1'b1}),
      .top       (bus.ras_top),
      .empty     (bus.ras_empty)
   );

   assign bus.lu_taken   = table_r[bus.lu_pc[IDX_W-1:0]][1];
   assign bus.out_valid  = out_valid_r;
   assign bus.out        = out_r;
   assign bus.taken      = taken_r;
   assign bus.mispredict = mp_r;
   assign bus.br_count   = br_count_r;
   assign bus.mp_count   = mp_count_r;
endmodule

// File: tb/tb_branch_predict_unit.sv
// Scoreboard bench for branch_predict_unit: a reference model predicts each
// registered result and the table/RAS/statistics state.
module tb_branch_predict_unit;
   localparam int DATA_W = 32, IDX_W = 6, RAS_DEPTH = 8, CNT_W = 16;

   typedef struct {
      logic        ov;
      logic [31:0] o;
      logic        tk;
      logic        mp;
   } exp_t;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   branch_predict_unit_if #(.DATA_W(DATA_W), .CNT_W(CNT_W)) bus ();

   branch_predict_unit #(
      .DATA_W(DATA_W), .IDX_W(IDX_W), .RAS_DEPTH(RAS_DEPTH), .CNT_W(CNT_W)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   exp_t        sb_q[$];
   logic [31:0] ras_q[$];
   int          tbl[64];
   int          br_m, mp_m;
   logic [31:0] last_o;
   logic        last_tk, last_mp;
   int          checks = 0, failures = 0;

   task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
      end
   endtask

   function automatic void ref_resolve(input logic [31:0] id, a, b, d, input logic pr,
                                       output logic tk, output logic [31:0] o, output logic mp);
      int sa, sb;
      sa = a;
      sb = b;
      tk = 1'b0; o = 32'd0; mp = 1'b0;
      case (id)
         32'd15: tk = (sa == sb);
         32'd16: tk = (sa != sb);
         32'd17: tk = (sa > sb);
         32'd18: tk = (sa >= sb);
         32'd19: tk = (sa < sb);
         32'd20: tk = (sa <= sb);
         32'd21, 32'd22, 32'd23: begin tk = 1'b1; o = a; mp = !pr; end
         default: ;
      endcase
      if (id >= 32'd15 && id <= 32'd20) begin
         o  = tk ? d : 32'd0;
         mp = tk ^ pr;
      end
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 64; i++) tbl[i] = 1;
      ras_q.delete();
      sb_q.delete();
      br_m = 0; mp_m = 0;
      last_o = 32'd0; last_tk = 1'b0; last_mp = 1'b0;
   endtask

   task automatic check_state(input string tag);
      check({tag, ".br_count"}, bus.br_count, br_m);
      check({tag, ".mp_count"}, bus.mp_count, mp_m);
      check({tag, ".ras_empty"}, bus.ras_empty, (ras_q.size() == 0));
      check({tag, ".ras_top"}, bus.ras_top, (ras_q.size() == 0) ? 32'd0 : ras_q[$]);
   endtask

   task automatic compare(input string tag);
      exp_t e;
      check({tag, ".sb_depth"}, sb_q.size(), 1);
      if (sb_q.size() > 0) begin
         e = sb_q.pop_front();
         check({tag, ".out_valid"}, bus.out_valid, e.ov);
         check({tag, ".out"}, bus.out, e.o);
         check({tag, ".taken"}, bus.taken, e.tk);
         check({tag, ".mispredict"}, bus.mispredict, e.mp);
      end
      check_state(tag);
   endtask

   task automatic resolve(input string tag, input logic [31:0] p, id, a, b, d, input logic pr);
      exp_t        e;
      logic        tk, mp;
      logic [31:0] o;
      int          ix;
      @(negedge clk);
      bus.valid = 1'b1; bus.pc = p; bus.ID = id; bus.rs = a; bus.rt = b;
      bus.rd = d; bus.pred_in = pr; bus.lu_pc = p;
      ix = int'(p[5:0]);
      #1 check({tag, ".lu_pre"}, bus.lu_taken, (tbl[ix] >= 2));
      ref_resolve(id, a, b, d, pr, tk, o, mp);
      e.ov = 1'b1; e.o = o; e.tk = tk; e.mp = mp;
      sb_q.push_back(e);
      if (id >= 32'd15 && id <= 32'd20) begin
         if (br_m < 65535) br_m++;
         if (tk && tbl[ix] < 3) tbl[ix]++;
         else if (!tk && tbl[ix] > 0) tbl[ix]--;
      end
      if (mp && mp_m < 65535) mp_m++;
      if (id == 32'd23) begin
         ras_q.push_back(p + 32'd1);
         if (ras_q.size() > RAS_DEPTH) void'(ras_q.pop_front());
      end else if (id == 32'd22 && ras_q.size() > 0) begin
         void'(ras_q.pop_back());
      end
      last_o = o; last_tk = tk; last_mp = mp;
      @(posedge clk);
      #1 compare(tag);
   endtask

   task automatic idle(input string tag, input logic [31:0] lp);
      exp_t e;
      @(negedge clk);
      bus.valid = 1'b0;
      bus.lu_pc = lp;
      #1 check({tag, ".lu"}, bus.lu_taken, (tbl[int'(lp[5:0])] >= 2));
      e.ov = 1'b0; e.o = last_o; e.tk = last_tk; e.mp = last_mp;
      sb_q.push_back(e);
      @(posedge clk);
      #1 compare(tag);
   endtask

   initial begin
      bus.valid = 1'b0; bus.pc = 32'd0; bus.ID = 32'd0; bus.rs = 32'd0;
      bus.rt = 32'd0; bus.rd = 32'd0; bus.pred_in = 1'b0; bus.lu_pc = 32'd0;
      reset = 1'b1;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      check("rst.out_valid", bus.out_valid, 1'b0);
      check("rst.out", bus.out, 32'd0);
      check("rst.taken", bus.taken, 1'b0);
      check("rst.mispredict", bus.mispredict, 1'b0);
      check("rst.lu_taken", bus.lu_taken, 1'b0);
      check_state("rst");
      @(negedge clk);
      reset = 1'b0;

      resolve("beq_nt", 32'd4, 32'd15, 32'd10, 32'd12, 32'd1, 1'b0);
      idle("hold", 32'd4);
      for (int i = 0; i < 4; i++) resolve("bne", 32'd8, 32'd16, 32'd10, 32'd12, 32'd2, 1'b0);
      idle("lu8", 32'd8);
      resolve("bgte_eq", 32'd12, 32'd18, 32'd10, 32'd10, 32'd99, 1'b0);
      resolve("ble_eq", 32'd12, 32'd19, 32'd10, 32'd10, 32'd99, 1'b0);
      resolve("bleq_neg", 32'd12, 32'd20, 32'hFFFF_FFFF, 32'd0, 32'd99, 1'b0);
      resolve("bgt_neg", 32'd13, 32'd17, 32'hFFFF_FFFF, 32'd0, 32'd7, 1'b1);

      resolve("jal", 32'd40, 32'd23, 32'd100, 32'd0, 32'd0, 1'b1);
      resolve("jr", 32'd44, 32'd22, 32'd5, 32'd0, 32'd0, 1'b1);
      resolve("jr_empty", 32'd44, 32'd22, 32'd5, 32'd0, 32'd0, 1'b1);
      for (int i = 0; i <= RAS_DEPTH; i++)
         resolve("jal_fill", i, 32'd23, 32'd200 + i, 32'd0, 32'd0, 1'b1);
      for (int i = 0; i < RAS_DEPTH; i++)
         resolve("jr_drain", 32'd60, 32'd22, 32'd7, 32'd0, 32'd0, 1'b1);

      resolve("rbw3", 32'd3, 32'd15, 32'd5, 32'd5, 32'd0, 1'b1);
      idle("lu3", 32'd3);
      resolve("bad_id", 32'd16, 32'd30, 32'd1, 32'd2, 32'd3, 1'b1);
      resolve("j_mp", 32'd17, 32'd21, 32'd77, 32'd0, 32'd0, 1'b0);

      for (int i = 0; i < 40; i++)
         resolve("rand", $urandom_range(0, 15), $urandom_range(14, 24),
                 $urandom_range(0, 3) - 1, $urandom_range(0, 3) - 1,
                 $urandom, 1'($urandom_range(0, 1)));

      @(negedge clk);
      reset = 1'b1;
      bus.valid = 1'b1; bus.ID = 32'd15; bus.rs = 32'd1; bus.rt = 32'd1;
      @(posedge clk);
      #1;
      model_reset();
      check("rst_mid.out_valid", bus.out_valid, 1'b0);
      check("rst_mid.lu_taken", bus.lu_taken, 1'b0);
      check_state("rst_mid");
      @(negedge clk);
      reset = 1'b0;
      bus.valid = 1'b0;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
